freq_meter: RTL and testbench



---
 rtl/freq_meter.sv | 117 +++++++++++
 tb/tb_freq_meter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges and high cycles of an asynchronous input
// over a fixed gate window of reference clock cycles.
module freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  localparam int HI_W       = $clog2(GATE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             freq_in,
  output logic [CNT_W-1:0] edge_count,
  output logic [HI_W-1:0]  high_count,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);

  localparam int GC_W = $clog2(GATE_CYCLES);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t            state;
  logic              s1, s2, prev;
  logic              rise;
  logic [GC_W-1:0]   gc;
  logic [CNT_W-1:0]  eacc, eacc_nxt;
  logic [HI_W-1:0]   hacc, hacc_nxt;
  logic              ovf, ovf_nxt;
  logic              edge_full;
  logic              last;

  // Synchronizer and edge-detect history; free-running in every state so a
  // window never opens on a stale edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= freq_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise      = s2 & ~prev;
  assign edge_full = (eacc == {CNT_W{1'b1}});
  assign last      = (gc == GC_W'(GATE_CYCLES - 1));

  // Accumulator next values including this cycle's contribution; the edge
  // count saturates and a further edge latches the sticky overflow.
  always_comb begin
    eacc_nxt = eacc;
    if (rise && !edge_full) eacc_nxt = eacc + CNT_W'(1);
    ovf_nxt  = ovf | (rise & edge_full);
    hacc_nxt = hacc + HI_W'(s2);
  end

  // Control FSM: gate counter, accumulators and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gc         <= '0;
      eacc       <= '0;
      hacc       <= '0;
      ovf        <= 1'b0;
      edge_count <= '0;
      high_count <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= MEASURE;
            busy  <= 1'b1;
            gc    <= '0;
            eacc  <= '0;
            hacc  <= '0;
            ovf   <= 1'b0;
          end
        end
        MEASURE: begin
          if (last) begin
            edge_count <= eacc_nxt;
            high_count <= hacc_nxt;
            overflow   <= ovf_nxt;
            valid      <= 1'b1;
            gc         <= '0;
            eacc       <= '0;
            hacc       <= '0;
            ovf        <= 1'b0;
            // Back-to-back windows: next window's first cycle is the next one.
            if (!continuous) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gc   <= gc + GC_W'(1);
            eacc <= eacc_nxt;
            hacc <= hacc_nxt;
            ovf  <= ovf_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: table-driven windows plus hand sequences, results checked
// by a scoreboard queue popped on each valid strobe.
module tb_freq_meter;
  localparam int GATE = 1000;

  logic        clk = 1'b0;
  logic        rst, start, start8, continuous, freq_in;
  logic [15:0] edge_count;
  logic [9:0]  high_count;
  logic        overflow, valid, busy;
  logic [7:0]  edge_count8;
  logic [9:0]  high_count8;
  logic        overflow8, valid8, busy8;

  freq_meter #(.GATE_CYCLES(GATE)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .freq_in(freq_in), .edge_count(edge_count), .high_count(high_count),
    .overflow(overflow), .valid(valid), .busy(busy));

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .continuous(1'b0),
    .freq_in(freq_in), .edge_count(edge_count8), .high_count(high_count8),
    .overflow(overflow8), .valid(valid8), .busy(busy8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; int edges; int highs; bit ovf; bit busy;
  } exp_t;
  exp_t q[$];
  exp_t q8[$];

  typedef struct {
    int p; int h; bit lvl; int edges; int highs;
  } vec_t;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input int act, input int expv);
    ntot++;
    if (act == expv) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Input generator: square wave of period gp (high gh) or a static level
  // with optional single-cycle pulses at chosen cycles.
  int gp = 0, gh = 0, ph = 0;
  bit glvl = 1'b0;
  int pe1 = -10, pe2 = -10;
  initial begin
    freq_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gp == 0) freq_in = glvl | (cyc == pe1) | (cyc == pe2);
      else         freq_in = ((ph % gp) < gh);
      ph++;
    end
  end

  // Scoreboard monitors, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid) begin
        if (q.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_valid: valid seen at cycle %0d, none expected", cyc);
        end else begin
          e = q.pop_front();
          chk("valid_cycle", cyc, e.cyc);
          chk("edge_count", int'(edge_count), e.edges);
          chk("high_count", int'(high_count), e.highs);
          chk("overflow", int'(overflow), int'(e.ovf));
          chk("busy_at_valid", int'(busy), int'(e.busy));
        end
      end
      if (valid8) begin
        if (q8.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_valid8: valid seen at cycle %0d, none expected", cyc);
        end else begin
          e = q8.pop_front();
          chk("valid8_cycle", cyc, e.cyc);
          chk("edge_count8", int'(edge_count8), e.edges);
          chk("high_count8", int'(high_count8), e.highs);
          chk("overflow8", int'(overflow8), int'(e.ovf));
          chk("busy8_at_valid", int'(busy8), int'(e.busy));
        end
      end
    end
  end

  task automatic pulse_start(output int t);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = cyc;
  endtask

  task automatic pulse_start8(output int t);
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    t = cyc;
  endtask

  task automatic push(input int t, input int e, input int h, input bit o, input bit b);
    exp_t x;
    x.cyc = t + GATE; x.edges = e; x.highs = h; x.ovf = o; x.busy = b;
    q.push_back(x);
  endtask

  task automatic push8(input int t, input int e, input int h, input bit o);
    exp_t x;
    x.cyc = t + GATE; x.edges = e; x.highs = h; x.ovf = o; x.busy = 1'b0;
    q8.push_back(x);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < budget) begin
      @(posedge clk); n++;
    end
    if (q.size() != 0 || q8.size() != 0) begin
      ntot++;
      $display("FAIL timeout: %0d results pending after %0d cycles, expected 0",
               q.size() + q8.size(), budget);
      q.delete(); q8.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic set_pat(input int p, input int h, input bit l);
    gp = p; gh = h; glvl = l;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int t, t2, prev_e;
    tbl[0] = '{10, 5, 1'b0, 100, 500};
    tbl[1] = '{ 0, 0, 1'b0,   0,   0};
    tbl[2] = '{ 0, 0, 1'b1,   0, 1000};
    tbl[3] = '{ 8, 4, 1'b0, 125, 500};
    tbl[4] = '{ 4, 1, 1'b0, 250, 250};
    tbl[5] = '{10, 3, 1'b0, 100, 300};

    rst = 1'b1; start = 1'b0; start8 = 1'b0; continuous = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_edge_count", int'(edge_count), 0);
    chk("rst_high_count", int'(high_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    start = 1'b1;                       // reset must win over start
    @(posedge clk); #1;
    chk("rst_over_start_busy", int'(busy), 0);
    start = 1'b0; rst = 1'b0;

    // Single-shot windows over a table of input patterns.
    prev_e = 0;
    for (int i = 0; i < 6; i++) begin
      set_pat(tbl[i].p, tbl[i].h, tbl[i].lvl);
      pulse_start(t);
      chk("busy_after_start", int'(busy), 1);
      chk("hold_edge_count", int'(edge_count), prev_e);
      push(t, tbl[i].edges, tbl[i].highs, 1'b0, 1'b0);
      repeat (GATE - 1) @(posedge clk);
      #1;
      chk("busy_last_cycle", int'(busy), 1);
      chk("valid_low_in_window", int'(valid), 0);
      wait_drain(200);
      chk("busy_after_done", int'(busy), 0);
      prev_e = tbl[i].edges;
    end

    // A second start during a window is ignored.
    set_pat(10, 5, 1'b0);
    pulse_start(t);
    push(t, 100, 500, 1'b0, 1'b0);
    repeat (298) @(posedge clk);
    pulse_start(t2);
    chk("busy_second_start", int'(busy), 1);
    wait_drain(1200);

    // Reset mid-window aborts and clears results.
    pulse_start(t);
    repeat (499) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_edge_count", int'(edge_count), 0);
    chk("abort_high_count", int'(high_count), 0);
    chk("abort_overflow", int'(overflow), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    repeat (1100) @(posedge clk);
    pulse_start(t);
    push(t, 100, 500, 1'b0, 1'b0);
    wait_drain(1200);

    // Continuous windows, continuous dropped during the third.
    set_pat(8, 4, 1'b0);
    continuous = 1'b1;
    pulse_start(t);
    push(t,        125, 500, 1'b0, 1'b1);
    push(t + 1000, 125, 500, 1'b0, 1'b1);
    push(t + 2000, 125, 500, 1'b0, 1'b0);
    while (cyc < t + 2500) @(posedge clk);
    #1 continuous = 1'b0;
    wait_drain(1500);
    repeat (1100) @(posedge clk);
    chk("busy_after_continuous", int'(busy), 0);

    // Saturation on the narrow counter, then recovery.
    set_pat(2, 1, 1'b0);
    pulse_start8(t);
    push8(t, 255, 500, 1'b1);
    wait_drain(1200);
    set_pat(10, 5, 1'b0);
    pulse_start8(t);
    push8(t, 100, 500, 1'b0);
    wait_drain(1200);

    // Window boundary: a rise on the last cycle stays in that window; a rise
    // on the first cycle of a later window belongs to that window.
    set_pat(0, 0, 1'b0);
    continuous = 1'b1;
    pulse_start(t);
    pe1 = t + GATE - 3;
    pe2 = t + 2 * GATE - 2;
    push(t,        1, 1, 1'b0, 1'b1);
    push(t + 1000, 0, 0, 1'b0, 1'b1);
    push(t + 2000, 1, 1, 1'b0, 1'b0);
    while (cyc < t + 2500) @(posedge clk);
    #1 continuous = 1'b0;
    wait_drain(1500);
    repeat (20) @(posedge clk);
    chk("busy_final", int'(busy), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
